systolic_skew_feeder: RTL and testbench

//  Upstream feeder for the NxN systolic MAC array. Buffers matrix A (K columns) and matrix B (K rows).
//  On start, streams A into the west edge (inp_west of row i) and B into the north edge (inp_north of column j).

---
 rtl/systolic_skew_feeder.sv | 198 +++++++++++++++++++
 tb/tb_systolic_skew_feeder.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/systolic_skew_feeder.sv
// Operand feeder for an NxN systolic MAC array: buffers A/B, then streams them skewed per lane.
// Optional macro FEEDER_RELOAD_EN keeps loaded operands across runs and adds i_clear_bufs.
module systolic_skew_feeder #(
    parameter int N  = 4,
    parameter int DW = 8,
    parameter int K  = 4
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_ld_valid,
    output logic            o_ld_ready,
    input  logic            i_ld_sel,
    input  logic [N*DW-1:0] i_ld_data,
    input  logic            i_start,
`ifdef FEEDER_RELOAD_EN
    input  logic            i_clear_bufs,
`endif
    output logic            o_start_err,
    output logic            o_busy,
    output logic            o_acc_clr,
    output logic [N*DW-1:0] o_west_out,
    output logic [N*DW-1:0] o_north_out,
    output logic            o_done
);

    localparam int TW = $clog2(K + N);
    localparam int CW = $clog2(K + 1);
    localparam int AW = (K > 1) ? $clog2(K) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CLR,
        S_FEED,
        S_DRAIN
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [TW-1:0]   r_t;
    logic [TW-1:0]   w_t_nxt;
    logic [CW-1:0]   r_a_cnt;
    logic [CW-1:0]   r_b_cnt;
    logic [DW-1:0]   r_a_buf [K][N];
    logic [DW-1:0]   r_b_buf [K][N];

    logic            w_a_full;
    logic            w_b_full;
    logic            w_ld_ready;
    logic            w_a_wr;
    logic            w_b_wr;
    logic            w_start_err_nxt;
    logic            w_done_nxt;
    logic [N*DW-1:0] w_west_nxt;
    logic [N*DW-1:0] w_north_nxt;

    logic            r_start_err;
    logic            r_busy;
    logic            r_acc_clr;
    logic [N*DW-1:0] r_west;
    logic [N*DW-1:0] r_north;
    logic            r_done;

    assign w_a_full   = (r_a_cnt == CW'(K));
    assign w_b_full   = (r_b_cnt == CW'(K));
    assign w_ld_ready = (r_state == S_IDLE) && (i_ld_sel ? !w_b_full : !w_a_full);
    assign w_a_wr     = i_ld_valid && w_ld_ready && !i_ld_sel;
    assign w_b_wr     = i_ld_valid && w_ld_ready && i_ld_sel;

    // Write pointers; loads can only land in IDLE, so they never collide with the drain-exit clear.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_a_cnt <= '0;
            r_b_cnt <= '0;
        end else begin
`ifdef FEEDER_RELOAD_EN
            if (r_state == S_IDLE && i_clear_bufs) begin
                r_a_cnt <= '0;
                r_b_cnt <= '0;
            end else begin
                if (w_a_wr) r_a_cnt <= r_a_cnt + CW'(1);
                if (w_b_wr) r_b_cnt <= r_b_cnt + CW'(1);
            end
`else
            if (r_state == S_DRAIN && w_state_nxt == S_IDLE) begin
                r_a_cnt <= '0;
                r_b_cnt <= '0;
            end else begin
                if (w_a_wr) r_a_cnt <= r_a_cnt + CW'(1);
                if (w_b_wr) r_b_cnt <= r_b_cnt + CW'(1);
            end
`endif
        end
    end

    always_ff @(posedge i_clk) begin
        for (int x = 0; x < N; x++) begin
            if (w_a_wr) r_a_buf[r_a_cnt[AW-1:0]][x] <= i_ld_data[x*DW +: DW];
            if (w_b_wr) r_b_buf[r_b_cnt[AW-1:0]][x] <= i_ld_data[x*DW +: DW];
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_IDLE;
            r_t     <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_t     <= w_t_nxt;
        end
    end

    // r_t indexes the skew step in FEED and is reused as the drain cycle counter.
    always_comb begin
        w_state_nxt     = r_state;
        w_t_nxt         = r_t;
        w_start_err_nxt = 1'b0;
        w_done_nxt      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    if (w_a_full && w_b_full) begin
                        w_state_nxt = S_CLR;
                        w_t_nxt     = '0;
                    end else begin
                        w_start_err_nxt = 1'b1;
                    end
                end
            end
            S_CLR: begin
                w_state_nxt = S_FEED;
                w_t_nxt     = '0;
            end
            S_FEED: begin
                if (r_t == TW'(K + N - 2)) begin
                    w_state_nxt = S_DRAIN;
                    w_t_nxt     = '0;
                end else begin
                    w_t_nxt = r_t + TW'(1);
                end
            end
            S_DRAIN: begin
                if (r_t == TW'(N)) begin
                    w_state_nxt = S_IDLE;
                    w_t_nxt     = '0;
                    w_done_nxt  = 1'b1;
                end else begin
                    w_t_nxt = r_t + TW'(1);
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_t_nxt     = '0;
            end
        endcase
        if (i_start && r_state != S_IDLE) w_start_err_nxt = 1'b1;
    end

    // Lane x carries beat t-x, so operands of matching k meet at PE (i,j) on step k+i+j.
    always_comb begin
        w_west_nxt  = '0;
        w_north_nxt = '0;
        if (w_state_nxt == S_FEED) begin
            for (int x = 0; x < N; x++) begin
                if (int'(w_t_nxt) >= x && int'(w_t_nxt) - x < K) begin
                    w_west_nxt[x*DW +: DW]  = r_a_buf[AW'(int'(w_t_nxt) - x)][x];
                    w_north_nxt[x*DW +: DW] = r_b_buf[AW'(int'(w_t_nxt) - x)][x];
                end
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_start_err <= 1'b0;
            r_busy      <= 1'b0;
            r_acc_clr   <= 1'b0;
            r_west      <= '0;
            r_north     <= '0;
            r_done      <= 1'b0;
        end else begin
            r_start_err <= w_start_err_nxt;
            r_busy      <= (w_state_nxt != S_IDLE);
            r_acc_clr   <= (w_state_nxt == S_CLR);
            r_west      <= w_west_nxt;
            r_north     <= w_north_nxt;
            r_done      <= w_done_nxt;
        end
    end

    assign o_ld_ready  = w_ld_ready;
    assign o_start_err = r_start_err;
    assign o_busy      = r_busy;
    assign o_acc_clr   = r_acc_clr;
    assign o_west_out  = r_west;
    assign o_north_out = r_north;
    assign o_done      = r_done;

endmodule

// File: tb/tb_systolic_skew_feeder.sv
// Scoreboard bench for systolic_skew_feeder (N=2, K=2, DW=8) with a behavioural 2x2 PE array.
// Define FEEDER_RELOAD_EN to exercise the reload variant.
module tb_systolic_skew_feeder;

    localparam int N  = 2;
    localparam int DW = 8;
    localparam int K  = 2;

    typedef struct packed {
        logic        accClr;
        logic        busy;
        logic [15:0] west;
        logic [15:0] north;
        logic        done;
    } rec_t;

    logic        clk;
    logic        rst;
    logic        ldValid;
    logic        ldReady;
    logic        ldSel;
    logic [15:0] ldData;
    logic        start;
    logic        clearBufs;
    logic        startErr;
    logic        busy;
    logic        accClr;
    logic [15:0] westOut;
    logic [15:0] northOut;
    logic        done;

    int   checks = 0;
    int   errors = 0;
    int   busyCnt = 0;
    logic lastReady;
    rec_t expQ[$];

    logic [7:0]  eastR  [2][2];
    logic [7:0]  southR [2][2];
    logic [31:0] acc    [2][2];
    logic [31:0] res    [2][2];

    systolic_skew_feeder #(.N(N), .DW(DW), .K(K)) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_ld_valid   (ldValid),
        .o_ld_ready   (ldReady),
        .i_ld_sel     (ldSel),
        .i_ld_data    (ldData),
        .i_start      (start),
`ifdef FEEDER_RELOAD_EN
        .i_clear_bufs (clearBufs),
`endif
        .o_start_err  (startErr),
        .o_busy       (busy),
        .o_acc_clr    (accClr),
        .o_west_out   (westOut),
        .o_north_out  (northOut),
        .o_done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural 2x2 output-stationary PE array fed by the DUT lanes.
    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            for (int j = 0; j < 2; j++) begin
                logic [7:0] w;
                logic [7:0] n;
                if (j == 0) w = westOut[i*8 +: 8];
                else        w = eastR[i][0];
                if (i == 0) n = northOut[j*8 +: 8];
                else        n = southR[0][j];
                if (accClr) begin
                    acc[i][j]    <= '0;
                    res[i][j]    <= '0;
                    eastR[i][j]  <= '0;
                    southR[i][j] <= '0;
                end else begin
                    acc[i][j]    <= acc[i][j] + 32'(w) * 32'(n);
                    res[i][j]    <= acc[i][j];
                    eastR[i][j]  <= w;
                    southR[i][j] <= n;
                end
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: pops one expected record for every cycle the DUT shows busy or done.
    always @(negedge clk) begin
        rec_t act;
        rec_t exp;
        act = '{accClr: accClr, busy: busy, west: westOut, north: northOut, done: done};
        if (busy || done) begin
            checks++;
            if (expQ.size() == 0) begin
                errors++;
                $display("[TB] FAIL unexpected_output: got %0h expected none", act);
            end else begin
                exp = expQ.pop_front();
                if (act !== exp) begin
                    errors++;
                    $display("[TB] FAIL lane_rec: got %0h expected %0h", act, exp);
                end
            end
        end
        if (rst) busyCnt = 0;
        else if (busy) busyCnt++;
        if (done) begin
            checkOutput("busy_cycles", 32'(busyCnt), 32'd7);
            checkOutput("c00", res[0][0], 32'd19);
            checkOutput("c01", res[0][1], 32'd22);
            checkOutput("c10", res[1][0], 32'd43);
            checkOutput("c11", res[1][1], 32'd50);
            busyCnt = 0;
        end
    end

    task automatic applyStimulus(input logic s, input logic v, input logic sel, input logic [15:0] d);
        start   = s;
        ldValid = v;
        ldSel   = sel;
        ldData  = d;
        #2;
        lastReady = ldReady;
        @(posedge clk);
        #1;
        start   = 1'b0;
        ldValid = 1'b0;
    endtask

    task automatic idleCycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic doClearBufs();
`ifdef FEEDER_RELOAD_EN
        clearBufs = 1'b1;
        @(posedge clk);
        #1;
        clearBufs = 1'b0;
`endif
    endtask

    task automatic loadAll();
        applyStimulus(1'b0, 1'b1, 1'b0, 16'h0301);
        applyStimulus(1'b0, 1'b1, 1'b0, 16'h0402);
        applyStimulus(1'b0, 1'b1, 1'b1, 16'h0605);
        applyStimulus(1'b0, 1'b1, 1'b1, 16'h0807);
    endtask

    task automatic pushRun(input int upto);
        rec_t seq [8];
        seq[0] = '{accClr: 1'b1, busy: 1'b1, west: 16'h0000, north: 16'h0000, done: 1'b0};
        seq[1] = '{accClr: 1'b0, busy: 1'b1, west: 16'h0001, north: 16'h0005, done: 1'b0};
        seq[2] = '{accClr: 1'b0, busy: 1'b1, west: 16'h0302, north: 16'h0607, done: 1'b0};
        seq[3] = '{accClr: 1'b0, busy: 1'b1, west: 16'h0400, north: 16'h0800, done: 1'b0};
        seq[4] = '{accClr: 1'b0, busy: 1'b1, west: 16'h0000, north: 16'h0000, done: 1'b0};
        seq[5] = '{accClr: 1'b0, busy: 1'b1, west: 16'h0000, north: 16'h0000, done: 1'b0};
        seq[6] = '{accClr: 1'b0, busy: 1'b1, west: 16'h0000, north: 16'h0000, done: 1'b0};
        seq[7] = '{accClr: 1'b0, busy: 1'b0, west: 16'h0000, north: 16'h0000, done: 1'b1};
        for (int i = 0; i < upto; i++) expQ.push_back(seq[i]);
    endtask

    task automatic waitDone();
        bit seen = 1'b0;
        for (int c = 0; c < 40; c++) begin
            if (done) begin
                seen = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
        end
        checkOutput("done_seen", 32'(seen), 32'd1);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst       = 1'b1;
        ldValid   = 1'b0;
        ldSel     = 1'b0;
        ldData    = '0;
        start     = 1'b0;
        clearBufs = 1'b0;
        idleCycles(2);
        rst = 1'b0;
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_west", 32'(westOut), 32'd0);
        checkOutput("rst_done", 32'(done), 32'd0);
        checkOutput("rst_ready", 32'(ldReady), 32'd1);

        // Basic product
        loadAll();
        pushRun(8);
        applyStimulus(1'b1, 1'b0, 1'b0, 16'h0000);
        checkOutput("t1_start_err", 32'(startErr), 32'd0);
        waitDone();

        // Start with an incomplete B buffer
        doClearBufs();
        applyStimulus(1'b0, 1'b1, 1'b0, 16'h0301);
        applyStimulus(1'b0, 1'b1, 1'b0, 16'h0402);
        applyStimulus(1'b0, 1'b1, 1'b1, 16'h0605);
        applyStimulus(1'b1, 1'b0, 1'b0, 16'h0000);
        checkOutput("t2_start_err", 32'(startErr), 32'd1);
        checkOutput("t2_busy", 32'(busy), 32'd0);
        ldSel = 1'b1;
        #1;
        checkOutput("t2_b_ready", 32'(ldReady), 32'd1);

        // Overfull A beat dropped; start with the final B beat rejected
        applyStimulus(1'b0, 1'b1, 1'b0, 16'h6363);
        checkOutput("t3_a_full_ready", 32'(lastReady), 32'd0);
        applyStimulus(1'b1, 1'b1, 1'b1, 16'h0807);
        checkOutput("t3_last_b_ready", 32'(lastReady), 32'd1);
        checkOutput("t3_start_err", 32'(startErr), 32'd1);
        pushRun(8);
        applyStimulus(1'b1, 1'b0, 1'b0, 16'h0000);
        checkOutput("t3_start_ok", 32'(startErr), 32'd0);
        waitDone();

        // Reset in the middle of FEED
        doClearBufs();
        loadAll();
        pushRun(3);
        applyStimulus(1'b1, 1'b0, 1'b0, 16'h0000);
        idleCycles(2);
        rst = 1'b1;
        idleCycles(1);
        rst = 1'b0;
        checkOutput("t4_busy", 32'(busy), 32'd0);
        checkOutput("t4_acc_clr", 32'(accClr), 32'd0);
        checkOutput("t4_west", 32'(westOut), 32'd0);
        checkOutput("t4_north", 32'(northOut), 32'd0);
        checkOutput("t4_done", 32'(done), 32'd0);
        checkOutput("t4_start_err", 32'(startErr), 32'd0);
        applyStimulus(1'b1, 1'b0, 1'b0, 16'h0000);
        checkOutput("t4_empty_start_err", 32'(startErr), 32'd1);
        loadAll();
        pushRun(8);
        applyStimulus(1'b1, 1'b0, 1'b0, 16'h0000);
        waitDone();

        // Start and load while busy
        doClearBufs();
        loadAll();
        pushRun(8);
        applyStimulus(1'b1, 1'b0, 1'b0, 16'h0000);
        applyStimulus(1'b1, 1'b1, 1'b0, 16'h5555);
        checkOutput("t5_busy_ready", 32'(lastReady), 32'd0);
        checkOutput("t5_start_err", 32'(startErr), 32'd1);
        checkOutput("t5_busy", 32'(busy), 32'd1);
        waitDone();

`ifdef FEEDER_RELOAD_EN
        // Immediate rerun on retained operands, then clear_bufs empties them
        pushRun(8);
        applyStimulus(1'b1, 1'b0, 1'b0, 16'h0000);
        checkOutput("t6_rerun_err", 32'(startErr), 32'd0);
        waitDone();
        doClearBufs();
        applyStimulus(1'b1, 1'b0, 1'b0, 16'h0000);
        checkOutput("t6_cleared_err", 32'(startErr), 32'd1);
`endif

        idleCycles(3);
        checkOutput("queue_empty", 32'(expQ.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
